// File: rtl/result_serializer_pkg.sv
// result_serializer_pkg: shared types, frame sizing and checksum helper for result_serializer
package result_serializer_pkg;
  localparam int RES_W = 67;
  localparam int FRAME_LEN_BASE = 9;
`ifdef RESULT_SER_CKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  typedef struct packed {
    logic [2:0] regime;
    logic signed [31:0] kappa;
    logic signed [31:0] inv_kappa;
  } result_t;
  typedef enum logic {IDLE, SEND} ser_state_t;
  function automatic logic [7:0] xor_bytes(input logic [FRAME_LEN_BASE*8-1:0] f);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < FRAME_LEN_BASE; i++) x ^= f[8*i +: 8];
    return x;
  endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO; a push while full or a pop while empty is ignored
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 67
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;
  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din_i;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/result_serializer.sv
// result_serializer: queues eig_core results and streams them as byte frames; RESULT_SER_CKSUM_EN appends an XOR checksum byte
module result_serializer
  import result_serializer_pkg::*;
#(
  parameter int         DEPTH     = 2,
  parameter logic [3:0] HDR_MAGIC = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid_i,
  input  logic [31:0] kappa_i,
  input  logic [31:0] inv_kappa_i,
  input  logic [2:0]  regime_i,
  output logic        res_ready_o,
  input  logic        out_ack_i,
  output logic [7:0]  out_byte_o,
  output logic        out_valid_o,
  output logic        busy_o,
  output logic        overflow_o
);
  ser_state_t state_q, state_d;
  logic [0:FRAME_LEN-1][7:0] frame_q, frame_d;
  logic [3:0] idx_q, idx_d;
  logic overflow_q, overflow_d;
  logic pop, full, empty;
  logic [$clog2(DEPTH):0] count;
  result_t head;
  logic [FRAME_LEN_BASE*8-1:0] base;
  result_fifo #(.DEPTH(DEPTH), .WIDTH(RES_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (res_valid_i),
    .pop_i   (pop),
    .din_i   ({regime_i, kappa_i, inv_kappa_i}),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign res_ready_o = ~full;
  assign out_valid_o = state_q == SEND;
  assign out_byte_o  = out_valid_o ? frame_q[idx_q] : 8'h00;
  assign busy_o      = (count != '0) | out_valid_o;
  assign overflow_o  = overflow_q;
  always_comb begin
    base = {HDR_MAGIC, 1'b0, head.regime, head.kappa, head.inv_kappa};
    state_d = state_q;
    frame_d = frame_q;
    idx_d = idx_q;
    overflow_d = overflow_q | (res_valid_i & full);
    pop = 1'b0;
    if (state_q == IDLE) begin
      if (!empty) begin
        pop = 1'b1;
        state_d = SEND;
        idx_d = '0;
`ifdef RESULT_SER_CKSUM_EN
        frame_d = {base, xor_bytes(base)};
`else
        frame_d = base;
`endif
      end
    end else if (out_ack_i) begin
      state_d = idx_q == 4'(FRAME_LEN - 1) ? IDLE : SEND;
      idx_d = idx_q == 4'(FRAME_LEN - 1) ? idx_q : idx_q + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed self-checking bench for result_serializer
module tb_result_serializer;
`ifdef RESULT_SER_CKSUM_EN
  localparam int FL = 10;
`else
  localparam int FL = 9;
`endif
  typedef logic [7:0] frame_t [10];
  logic clk = 1'b0;
  logic rst, res_valid_i, out_ack_i;
  logic [31:0] kappa_i, inv_kappa_i;
  logic [2:0] regime_i;
  logic res_ready_o, out_valid_o, busy_o, overflow_o;
  logic [7:0] out_byte_o;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  result_serializer #(.DEPTH(2), .HDR_MAGIC(4'hA)) dut (
    .clk         (clk),
    .rst         (rst),
    .res_valid_i (res_valid_i),
    .kappa_i     (kappa_i),
    .inv_kappa_i (inv_kappa_i),
    .regime_i    (regime_i),
    .res_ready_o (res_ready_o),
    .out_ack_i   (out_ack_i),
    .out_byte_o  (out_byte_o),
    .out_valid_o (out_valid_o),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic frame_t model(input logic [31:0] k, input logic [31:0] ik, input logic [2:0] r);
    frame_t f;
    f[0] = {4'hA, 1'b0, r};
    for (int i = 0; i < 4; i++) begin
      f[1+i] = k[31-8*i -: 8];
      f[5+i] = ik[31-8*i -: 8];
    end
    f[9] = 8'h00;
    for (int i = 0; i < 9; i++) f[9] ^= f[i];
    return f;
  endfunction
  task automatic push(input logic [31:0] k, input logic [31:0] ik, input logic [2:0] r);
    kappa_i = k; inv_kappa_i = ik; regime_i = r; res_valid_i = 1'b1;
    @(negedge clk);
    res_valid_i = 1'b0;
  endtask
  task automatic recv(input frame_t exp, input int gap, input int nb, input string tag);
    int n;
    for (int i = 0; i < nb; i++) begin
      n = 0;
      while (!out_valid_o && n < 40) begin @(negedge clk); n++; end
      check($sformatf("%s valid%0d", tag, i), 32'(out_valid_o), 1);
      for (int h = 0; h < gap; h++) begin
        check($sformatf("%s hold%0d", tag, i), 32'(out_byte_o), 32'(exp[i]));
        @(negedge clk);
      end
      check($sformatf("%s byte%0d", tag, i), 32'(out_byte_o), 32'(exp[i]));
      out_ack_i = 1'b1;
      @(negedge clk);
      out_ack_i = 1'b0;
    end
  endtask
  initial begin
    frame_t f1, fz;
    int stale;
    f1 = '{8'hA3, 8'h12, 8'h34, 8'h56, 8'h78, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h62};
    fz = '{8'hA7, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA7};
    rst = 1'b1; res_valid_i = 1'b0; out_ack_i = 1'b0;
    kappa_i = '0; inv_kappa_i = '0; regime_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst valid", 32'(out_valid_o), 0);
    check("rst byte", 32'(out_byte_o), 0);
    check("rst busy", 32'(busy_o), 0);
    check("rst ovf", 32'(overflow_o), 0);
    check("rst ready", 32'(res_ready_o), 1);
    // single frame, ack every cycle
    push(32'h12345678, 32'hCAFEF00D, 3'd3);
    check("single pre", 32'(out_valid_o), 0);
    check("single busy", 32'(busy_o), 1);
    @(negedge clk);
    recv(f1, 0, FL, "single");
    check("single post", 32'(out_valid_o), 0);
    check("single idle busy", 32'(busy_o), 0);
    // backpressure, ack every 4th cycle
    push(32'h12345678, 32'hCAFEF00D, 3'd3);
    recv(f1, 3, FL, "bp");
    check("bp post", 32'(out_valid_o), 0);
    // overflow with a frame already in flight
    push(32'h11111111, 32'h22222222, 3'd1);
    kappa_i = 32'h33333333; inv_kappa_i = 32'h44444444; regime_i = 3'd2; res_valid_i = 1'b1;
    @(negedge clk);
    kappa_i = 32'h55555555; inv_kappa_i = 32'h66666666; regime_i = 3'd4;
    @(negedge clk);
    check("ovf ready", 32'(res_ready_o), 0);
    kappa_i = 32'h77777777; inv_kappa_i = 32'h88888888; regime_i = 3'd6;
    @(negedge clk);
    res_valid_i = 1'b0;
    check("ovf flag", 32'(overflow_o), 1);
    check("ovf ready2", 32'(res_ready_o), 0);
    recv(model(32'h11111111, 32'h22222222, 3'd1), 0, FL, "ovf f0");
    recv(model(32'h33333333, 32'h44444444, 3'd2), 0, FL, "ovf f1");
    recv(model(32'h55555555, 32'h66666666, 3'd4), 0, FL, "ovf f2");
    stale = 0;
    repeat (15) begin stale += int'(out_valid_o); @(negedge clk); end
    check("ovf no extra", 32'(stale), 0);
    check("ovf sticky", 32'(overflow_o), 1);
    // back-to-back frames with regimes 5 and 6
    push(32'h80000001, 32'h7FFFFFFE, 3'd5);
    push(32'hDEADBEEF, 32'h01020304, 3'd6);
    recv(model(32'h80000001, 32'h7FFFFFFE, 3'd5), 0, FL, "b2b f0");
    check("b2b gap", 32'(out_valid_o), 0);
    check("b2b gap busy", 32'(busy_o), 1);
    @(negedge clk);
    check("b2b restart", 32'(out_valid_o), 1);
    recv(model(32'hDEADBEEF, 32'h01020304, 3'd6), 0, FL, "b2b f1");
    check("b2b busy fall", 32'(busy_o), 0);
    check("b2b end", 32'(out_valid_o), 0);
    // reset mid-frame with a second result queued
    push(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd2);
    push(32'h0BADF00D, 32'h13579BDF, 3'd1);
    recv(model(32'hA5A5A5A5, 32'h5A5A5A5A, 3'd2), 0, 5, "mid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid valid", 32'(out_valid_o), 0);
    check("mid busy", 32'(busy_o), 0);
    check("mid ready", 32'(res_ready_o), 1);
    check("mid ovf", 32'(overflow_o), 0);
    check("mid byte", 32'(out_byte_o), 0);
    stale = 0;
    repeat (20) begin stale += int'(out_valid_o); @(negedge clk); end
    check("mid no stale", 32'(stale), 0);
    // spurious ack while idle
    out_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    out_ack_i = 1'b0;
    check("spur valid", 32'(out_valid_o), 0);
    push(32'h00000000, 32'hFFFFFFFF, 3'd7);
    recv(fz, 0, FL, "spur");
    check("spur end", 32'(out_valid_o), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
